// File: rtl/top_if.sv
// Signal bundle for the AND/sync/count block: raw operands in, combinational
// and registered results, counters and coverage out.
interface top_if #(
  parameter int CNT_W = 8,
  parameter int HI_W  = 16
);
  logic             a;
  logic             b;
  logic             c;
  logic             c_q;
  logic [CNT_W-1:0] rise_cnt;
  logic [HI_W-1:0]  hi_cnt;
  logic [3:0]       seen;
  logic             all_seen;

  modport master (
    output a, b,
    input  c, c_q, rise_cnt, hi_cnt, seen, all_seen
  );

  modport slave (
    input  a, b,
    output c, c_q, rise_cnt, hi_cnt, seen, all_seen
  );
endinterface

// File: rtl/top.sv
// AND of two asynchronous operands: a zero-latency combinational output plus a
// synchronized, registered path with saturating rise/high counters and coverage.
module top #(
  parameter int CNT_W = 8,
  parameter int HI_W  = 16
) (
  input  logic  clk,
  input  logic  rst,
  top_if.slave  bus
);

  // index 1 = a, index 0 = b, so {a_s,b_s} can index the coverage vector directly
  logic [1:0]       raw_in;
  logic [1:0]       meta_q, meta_d;
  logic [1:0]       sync_q, sync_d;
  logic             and_q, and_d;
  logic             and_prev_q, and_prev_d;
  logic [CNT_W-1:0] rise_q, rise_d;
  logic [HI_W-1:0]  hi_q, hi_d;
  logic [3:0]       seen_q, seen_d;

  assign raw_in = {bus.a, bus.b};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      always_comb begin
        meta_d[gi] = raw_in[gi];
        sync_d[gi] = meta_q[gi];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          meta_q[gi] <= 1'b0;
          sync_q[gi] <= 1'b0;
        end else begin
          meta_q[gi] <= meta_d[gi];
          sync_q[gi] <= sync_d[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    and_d      = sync_q[1] & sync_q[0];
    and_prev_d = and_q;

    // and_prev_q is zero after reset, so the first high c_q counts as a rise
    rise_d = rise_q;
    if (and_q && !and_prev_q && (rise_q != {CNT_W{1'b1}})) begin
      rise_d = rise_q + CNT_W'(1);
    end

    hi_d = hi_q;
    if (and_q && (hi_q != {HI_W{1'b1}})) begin
      hi_d = hi_q + HI_W'(1);
    end

    seen_d         = seen_q;
    seen_d[sync_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      and_q      <= 1'b0;
      and_prev_q <= 1'b0;
      rise_q     <= '0;
      hi_q       <= '0;
      seen_q     <= '0;
    end else begin
      and_q      <= and_d;
      and_prev_q <= and_prev_d;
      rise_q     <= rise_d;
      hi_q       <= hi_d;
      seen_q     <= seen_d;
    end
  end

  // Combinational path is deliberately independent of clk and rst
  assign bus.c        = bus.a & bus.b;
  assign bus.c_q      = and_q;
  assign bus.rise_cnt = rise_q;
  assign bus.hi_cnt   = hi_q;
  assign bus.seen     = seen_q;
  assign bus.all_seen = &seen_q;

endmodule

// File: tb/tb_top.sv
// Bench for top: directed scenarios plus randomized operands and resets, with
// two instances (default widths and narrow counters) checked against a model.
module tb_top;

  logic clk;
  logic rst;
  logic a;
  logic b;
  bit   clk_en;

  int n_checks;
  int n_fail;

  top_if #(.CNT_W(8), .HI_W(16)) bus_l ();
  top_if #(.CNT_W(2), .HI_W(4))  bus_s ();

  assign bus_l.a = a;
  assign bus_l.b = b;
  assign bus_s.a = a;
  assign bus_s.b = b;

  top #(.CNT_W(8), .HI_W(16)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));
  top #(.CNT_W(2), .HI_W(4))  dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: operands reach the AND two edges after being sampled,
  // c_q is that AND one edge later; counters/coverage follow from c_q history.
  int         m_rise[2];
  int         m_hi[2];
  int         rise_max[2] = '{255, 3};
  int         hi_max[2]   = '{65535, 15};
  logic [3:0] m_seen;
  bit         m_cq;
  bit         m_cq_prev;
  logic [1:0] samp[$];

  initial begin
    logic [1:0] as_b;
    bit         cq_b;
    int         n;
    forever begin
      @(posedge clk or posedge rst);
      if (rst === 1'b1) begin
        m_rise    = '{0, 0};
        m_hi      = '{0, 0};
        m_seen    = 4'b0000;
        m_cq      = 1'b0;
        m_cq_prev = 1'b0;
        samp.delete();
      end else if (rst === 1'b0) begin
        n    = samp.size();
        as_b = (n >= 2) ? samp[n-2] : 2'b00;
        cq_b = m_cq;
        for (int i = 0; i < 2; i++) begin
          if (cq_b && m_hi[i] < hi_max[i]) m_hi[i]++;
          if (cq_b && !m_cq_prev && m_rise[i] < rise_max[i]) m_rise[i]++;
        end
        m_seen    = m_seen | (4'b0001 << as_b);
        m_cq_prev = cq_b;
        m_cq      = as_b[1] & as_b[0];
        samp.push_back({a, b});
        if (samp.size() > 2) void'(samp.pop_front());
      end
    end
  end

  bit mdl_en;

  initial begin
    forever begin
      @(negedge clk);
      if (mdl_en) begin
        check("mdl_cq_l",    32'(bus_l.c_q),      32'(m_cq));
        check("mdl_rise_l",  32'(bus_l.rise_cnt), 32'(m_rise[0]));
        check("mdl_hi_l",    32'(bus_l.hi_cnt),   32'(m_hi[0]));
        check("mdl_seen_l",  32'(bus_l.seen),     32'(m_seen));
        check("mdl_all_l",   32'(bus_l.all_seen), 32'(m_seen == 4'hf));
        check("mdl_cq_s",    32'(bus_s.c_q),      32'(m_cq));
        check("mdl_rise_s",  32'(bus_s.rise_cnt), 32'(m_rise[1]));
        check("mdl_hi_s",    32'(bus_s.hi_cnt),   32'(m_hi[1]));
      end
    end
  end

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_cq"},   32'(bus_l.c_q),      32'd0);
    check({tag, "_rise"}, 32'(bus_l.rise_cnt), 32'd0);
    check({tag, "_hi"},   32'(bus_l.hi_cnt),   32'd0);
    check({tag, "_seen"}, 32'(bus_l.seen),     32'd0);
    check({tag, "_all"},  32'(bus_l.all_seen), 32'd0);
    check({tag, "_c"},    32'(bus_l.c),        32'(a & b));
    check({tag, "_rise_s"}, 32'(bus_s.rise_cnt), 32'd0);
  endtask

  // Mid-cycle reset pulse, starting from a negative edge
  task automatic reset_pulse(input string tag);
    #2 rst = 1'b1;
    #1 check_cleared(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [1:0] ab;
    int         lat;
    rst    = 1'bx;
    a      = 1'b0;
    b      = 1'b0;
    clk_en = 1'b0;
    mdl_en = 1'b0;

    // Combinational path with no clock and reset unknown
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      {a, b} = ab;
      #10;
      check("comb_c_l", 32'(bus_l.c), 32'(i == 3));
      check("comb_c_s", 32'(bus_s.c), 32'(i == 3));
    end

    a = 1'b0;
    b = 1'b0;
    rst = 1'b1;
    #3;
    check_cleared("rst_init");
    clk_en = 1'b1;
    ticks(2);
    rst = 1'b0;
    mdl_en = 1'b1;
    ticks(3);

    // Latency: count rising edges until c_q is seen high
    a = 1'b1;
    b = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (bus_l.c_q === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("lat_cq", 32'(lat), 32'd3);
    @(posedge clk);
    #1 check("lat_rise", 32'(bus_l.rise_cnt), 32'd1);
    @(negedge clk);

    // Count: five high cycles then b low
    a = 1'b0;
    b = 1'b0;
    reset_pulse("rst_cnt");
    ticks(1);
    a = 1'b1;
    b = 1'b1;
    ticks(5);
    b = 1'b0;
    ticks(6);
    check("cnt_hi",   32'(bus_l.hi_cnt),   32'd5);
    check("cnt_rise", 32'(bus_l.rise_cnt), 32'd1);

    // Saturation: five separated pulses of four cycles each
    reset_pulse("rst_sat");
    a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b = 1'b1;
      ticks(4);
      b = 1'b0;
      ticks(4);
    end
    ticks(4);
    check("sat_rise_s", 32'(bus_s.rise_cnt), 32'd3);
    check("sat_rise_l", 32'(bus_l.rise_cnt), 32'd5);
    check("sat_hi_s",   32'(bus_s.hi_cnt),   32'd15);
    check("sat_hi_l",   32'(bus_l.hi_cnt),   32'd20);

    // Coverage: every operand pair held four cycles
    reset_pulse("rst_cov");
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      {a, b} = ab;
      ticks(4);
    end
    ticks(1);
    check("cov_seen", 32'(bus_l.seen),     32'hf);
    check("cov_all",  32'(bus_l.all_seen), 32'd1);
    reset_pulse("rst_cov_clr");
    ticks(1);

    // Randomized operands with occasional mid-cycle resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        a = 1'($urandom);
        b = 1'($urandom);
      end
      #1 check("rnd_c", 32'(bus_l.c), 32'(a & b));
      if ($urandom_range(0, 79) == 0) begin
        reset_pulse("rnd_rst");
      end
      @(negedge clk);
    end

    mdl_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter CNT_W, default 8, width of the rising-edge counter rise_cnt.
REQ-002 Parameter HI_W, default 16, width of the high-cycle counter hi_cnt.
REQ-003 Clocking is decided: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 a  input  1  first logic operand; asynchronous to clk.
REQ-007 b  input  1  second logic operand; asynchronous to clk.
REQ-008 c  output  1  combinational AND of a and b.
REQ-009 c_q  output  1  registered AND of the synchronized a and b.
REQ-010 rise_cnt  output  CNT_W  count of c_q 0->1 transitions, saturating.
REQ-011 hi_cnt  output  HI_W  count of clk cycles with c_q=1, saturating.
REQ-012 seen  output  4  sticky coverage of input combinations; bit index = {a_s,b_s}.
REQ-013 all_seen  output  1  high when seen equals 4'b1111.

Function
REQ-014 c SHALL equal a & b, purely combinational, with zero clock latency.
REQ-015 c SHALL NOT depend on clk or rst; correct with clk undriven and rst undriven/X.
REQ-016 Truth table for c: 00->0, 01->0, 10->0, 11->1.
REQ-017 a and b SHALL each pass through a 2-flop synchronizer to give a_s and b_s.
REQ-018 c_q SHALL be registered as a_s & b_s, giving 3 clk cycles from input change to c_q.
REQ-019 rise_cnt SHALL increment by 1 in the cycle after c_q goes 0->1.
REQ-020 rise_cnt SHALL hold at all-ones instead of wrapping.
REQ-021 hi_cnt SHALL increment by 1 on every clk edge that samples c_q=1.
REQ-022 hi_cnt SHALL saturate at all-ones.
REQ-023 On each clk edge, seen[{a_s,b_s}] SHALL be set to 1.
REQ-024 seen bits SHALL clear only on reset.
REQ-025 all_seen SHALL be combinational from seen.
REQ-026 Input glitches shorter than one clk period MAY be missed by the registered path and SHALL NOT be required to be counted.
REQ-027 c SHALL still reflect such glitches.
REQ-028 The registered path SHALL have no other state and no handshakes.

Reset
REQ-029 While rst=1, the synchronizer flops, c_q, rise_cnt, hi_cnt and seen SHALL be 0 immediately, without waiting for a clk edge.
REQ-030 all_seen SHALL be 0 during reset.
REQ-031 c SHALL keep following a & b during reset.
REQ-032 After rst deasserts, the registered path resumes on the next clk rising edge.
REQ-033 Post-reset history SHALL start fresh: the first c_q=1 counts as a rise.
REQ-034 Reset asserted mid-operation SHALL discard all counts and coverage.

Verification
REQ-035 Combinational test, no clock: apply a,b = 00, 01, 10, 11, 10 ns apart, sampling at each 10 ns step -> c = 0, 0, 0, 1.
REQ-036 Latency test: rst pulse, then a=b=1 held -> c_q rises exactly on the 3rd clk edge after the input change; rise_cnt=1 on the next edge.
REQ-037 Counting test: a=b=1 for 5 clk cycles, then b=0 -> hi_cnt=5, rise_cnt=1.
REQ-038 Saturation test: with CNT_W=2, toggle b 5 times with a=1 and each phase lasting at least 4 cycles -> rise_cnt stays at 3.
REQ-039 Coverage test: step through all four (a,b) pairs, each held 4 cycles -> seen=4'b1111 and all_seen=1; then assert rst between clk edges -> seen=0 immediately.
REQ-040 Async reset test: assert rst mid-cycle with nonzero counts -> all registered outputs are 0 before the next clk edge, while c still equals a & b.
